// File: rtl/compare_debounce_pkg.sv
// ---------------------------------------------------------------------------
// compare_debounce_pkg : state encoding and parameter bounds for the
// comparator debounce stage.          Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package compare_debounce_pkg;

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      CONF_HI = 2'd1,
      HIGH    = 2'd2,
      CONF_LO = 2'd3
   } state_t;

   localparam int DEBOUNCE_MIN = 1;
   localparam int DEBOUNCE_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : width-parameterised event counter, saturates at all-ones,
// synchronous clear has priority over increment.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/compare_debounce_fsm.sv
// ---------------------------------------------------------------------------
// compare_debounce_fsm : debounced, hysteretic "above threshold" level with
// rise/fall pulses, saturating event counters and illegal-verdict flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module compare_debounce_fsm
   import compare_debounce_pkg::*;
#(
   parameter int DEBOUNCE = 3,
   parameter int RUN_W    = 4,
   parameter int EVT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             eq,
   input  logic             lt,
   input  logic             gt,
   input  logic             clear,
   output logic             above,
   output logic             rise,
   output logic             fall,
   output logic             err,
   output logic [EVT_W-1:0] rise_count,
   output logic [EVT_W-1:0] fall_count,
   output logic [1:0]       state
);

   if ((DEBOUNCE < DEBOUNCE_MIN) || (DEBOUNCE > DEBOUNCE_MAX) ||
       (DEBOUNCE > (2**RUN_W) - 1)) begin : g_bad_debounce
      $error("compare_debounce_fsm: DEBOUNCE out of range");
   end

   localparam logic [RUN_W-1:0] c_run_one  = RUN_W'(1);
   localparam logic [RUN_W-1:0] c_deb_goal = RUN_W'(DEBOUNCE);

   state_t           r_state;
   state_t           w_state_nx;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_nx;
   logic [RUN_W-1:0] w_run_inc;
   logic             r_rise;
   logic             r_fall;
   logic             r_err;
   logic             w_rise_nx;
   logic             w_fall_nx;
   logic             w_legal;
   logic             w_illegal;

   // Exactly one verdict flag high.
   assign w_legal   = in_valid && ((eq ^ lt ^ gt) && !(eq && lt && gt));
   assign w_illegal = in_valid && !w_legal;
   assign w_run_inc = r_run + c_run_one;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOW;
         r_run   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_run   <= w_run_nx;
         r_rise  <= w_rise_nx;
         r_fall  <= w_fall_nx;
         if (w_illegal) begin
            r_err <= 1'b1;
         end else if (clear) begin
            r_err <= 1'b0;
         end
      end
   end

   // eq inside a confirmation holds the run: that is the hysteresis band.
   always_comb begin
      w_state_nx = r_state;
      w_run_nx   = r_run;
      w_rise_nx  = 1'b0;
      w_fall_nx  = 1'b0;
      if (w_legal) begin
         unique case (r_state)
            LOW: begin
               if (gt) begin
                  if (DEBOUNCE == 1) begin
                     w_state_nx = HIGH;
                     w_rise_nx  = 1'b1;
                  end else begin
                     w_state_nx = CONF_HI;
                     w_run_nx   = c_run_one;
                  end
               end
            end
            CONF_HI: begin
               if (gt) begin
                  if (w_run_inc == c_deb_goal) begin
                     w_state_nx = HIGH;
                     w_run_nx   = '0;
                     w_rise_nx  = 1'b1;
                  end else begin
                     w_run_nx   = w_run_inc;
                  end
               end else if (lt) begin
                  w_state_nx = LOW;
                  w_run_nx   = '0;
               end
            end
            HIGH: begin
               if (lt) begin
                  if (DEBOUNCE == 1) begin
                     w_state_nx = LOW;
                     w_fall_nx  = 1'b1;
                  end else begin
                     w_state_nx = CONF_LO;
                     w_run_nx   = c_run_one;
                  end
               end
            end
            CONF_LO: begin
               if (lt) begin
                  if (w_run_inc == c_deb_goal) begin
                     w_state_nx = LOW;
                     w_run_nx   = '0;
                     w_fall_nx  = 1'b1;
                  end else begin
                     w_run_nx   = w_run_inc;
                  end
               end else if (gt) begin
                  w_state_nx = HIGH;
                  w_run_nx   = '0;
               end
            end
         endcase
      end
   end

   // Counters step on the same edge that launches the pulse.
   sat_counter #(.WIDTH(EVT_W)) u_rise_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_rise_nx),
      .clr   (clear),
      .count (rise_count)
   );

   sat_counter #(.WIDTH(EVT_W)) u_fall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_fall_nx),
      .clr   (clear),
      .count (fall_count)
   );

   assign above = (r_state == HIGH) || (r_state == CONF_LO);
   assign rise  = r_rise;
   assign fall  = r_fall;
   assign err   = r_err;
   assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_compare_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_compare_debounce_fsm : directed and random stimulus against a level /
// pending-count reference model.      Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_compare_debounce_fsm;

   localparam int DEB   = 3;
   localparam int EVT_W = 8;
   localparam int SAT   = (1 << EVT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             eq = 1'b0;
   logic             lt = 1'b0;
   logic             gt = 1'b0;
   logic             clear = 1'b0;
   logic             above;
   logic             rise;
   logic             fall;
   logic             err;
   logic [EVT_W-1:0] rise_count;
   logic [EVT_W-1:0] fall_count;
   logic [1:0]       state;

   int checks = 0;
   int passes = 0;

   // Reference model: debounced level plus count of consecutive qualifying samples.
   bit m_above;
   int m_pend;
   bit m_rise;
   bit m_fall;
   bit m_err;
   int m_rc;
   int m_fc;

   compare_debounce_fsm #(
      .DEBOUNCE (DEB),
      .RUN_W    (4),
      .EVT_W    (EVT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .eq         (eq),
      .lt         (lt),
      .gt         (gt),
      .clear      (clear),
      .above      (above),
      .rise       (rise),
      .fall       (fall),
      .err        (err),
      .rise_count (rise_count),
      .fall_count (fall_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_above = 0; m_pend = 0; m_rise = 0; m_fall = 0;
      m_err = 0; m_rc = 0; m_fc = 0;
   endtask

   task automatic model_step(input bit v, input bit e, input bit l, input bit g, input bit c);
      bit legal;
      legal  = v && ((int'(e) + int'(l) + int'(g)) == 1);
      m_rise = 0;
      m_fall = 0;
      if (v && !legal) m_err = 1;
      else if (c)      m_err = 0;
      if (legal) begin
         if (!m_above) begin
            if (g) begin
               m_pend++;
               if (m_pend == DEB) begin m_above = 1; m_pend = 0; m_rise = 1; end
            end else if (l) m_pend = 0;
         end else begin
            if (l) begin
               m_pend++;
               if (m_pend == DEB) begin m_above = 0; m_pend = 0; m_fall = 1; end
            end else if (g) m_pend = 0;
         end
      end
      if (c)           m_rc = 0;
      else if (m_rise) m_rc = (m_rc < SAT) ? m_rc + 1 : SAT;
      if (c)           m_fc = 0;
      else if (m_fall) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
   endtask

   task automatic check_all(input string tag);
      int exp_state;
      exp_state = m_above ? ((m_pend != 0) ? 3 : 2) : ((m_pend != 0) ? 1 : 0);
      chk({tag, ".state"},      32'(state),      32'(exp_state));
      chk({tag, ".above"},      32'(above),      32'(m_above));
      chk({tag, ".rise"},       32'(rise),       32'(m_rise));
      chk({tag, ".fall"},       32'(fall),       32'(m_fall));
      chk({tag, ".err"},        32'(err),        32'(m_err));
      chk({tag, ".rise_count"}, 32'(rise_count), 32'(m_rc));
      chk({tag, ".fall_count"}, 32'(fall_count), 32'(m_fc));
   endtask

   task automatic step(input string tag, input bit v, input bit e, input bit l,
                       input bit g, input bit c);
      in_valid = v; eq = e; lt = l; gt = g; clear = c;
      @(posedge clk);
      model_step(v, e, l, g, c);
      #1;
      in_valid = 0; clear = 0;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic rise after three gt samples.
      step("rise1", 1, 0, 0, 1, 0);
      step("rise2", 1, 0, 0, 1, 0);
      step("rise3", 1, 0, 0, 1, 0);
      step("idle",  0, 1, 1, 1, 0);

      // HIGH: lt,lt,gt returns to HIGH without a fall.
      step("clo1", 1, 0, 1, 0, 0);
      step("clo2", 1, 0, 1, 0, 0);
      step("clo3", 1, 0, 0, 1, 0);
      // Fall back to LOW.
      repeat (3) step("fall", 1, 0, 1, 0, 0);

      // Hysteresis: gt,eq,eq,gt,gt.
      step("hys1", 1, 0, 0, 1, 0);
      step("hys2", 1, 1, 0, 0, 0);
      step("hys3", 1, 1, 0, 0, 0);
      step("hys4", 1, 0, 0, 1, 0);
      step("hys5", 1, 0, 0, 1, 0);
      step("hys6", 1, 1, 0, 0, 0);

      // Illegal verdicts, then clear.
      step("ill0", 1, 0, 0, 0, 0);
      step("ill2", 1, 0, 1, 1, 0);
      step("clr",  0, 0, 0, 0, 1);
      step("illc", 1, 1, 1, 1, 1);
      step("clr2", 0, 0, 0, 0, 1);

      // Saturation over 300 full cycles.
      for (int i = 0; i < 300; i++) begin
         repeat (DEB) step("sat_lt", 1, 0, 1, 0, 0);
         repeat (DEB) step("sat_gt", 1, 0, 0, 1, 0);
      end
      repeat (DEB) step("sat_lt", 1, 0, 1, 0, 0);
      step("pre_c1", 1, 0, 0, 1, 0);
      step("pre_c2", 1, 0, 0, 1, 0);
      step("rise_clr", 1, 0, 0, 1, 1);

      // Asynchronous reset mid-confirmation.
      repeat (DEB) step("down", 1, 0, 1, 0, 0);
      step("conf1", 1, 0, 0, 1, 0);
      step("conf2", 1, 0, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post1", 1, 0, 0, 1, 0);
      step("post2", 1, 0, 0, 1, 0);
      step("post3", 1, 0, 0, 1, 0);

      // Random phase.
      for (int i = 0; i < 500; i++) begin
         bit v, e, l, g, c;
         int sel;
         v   = ($urandom_range(0, 9) != 0);
         c   = ($urandom_range(0, 24) == 0);
         sel = $urandom_range(0, 19);
         if (sel < 18) begin
            e = (sel % 3 == 0); l = (sel % 3 == 1); g = (sel % 3 == 2);
         end else begin
            {e, l, g} = 3'($urandom_range(0, 7));
         end
         step("rand", v, e, l, g, c);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/compare_debounce_fsm.md
Name: compare_debounce_fsm

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes one comparator verdict per valid cycle (eq/lt/gt for sample a vs threshold b).
- Produces a debounced, hysteretic "above threshold" level, single-cycle rise/fall event pulses, and saturating event counters.
- Also flags illegal verdict encodings from the comparator.

Parameters:
- DEBOUNCE, 3, consecutive qualifying samples required to change level; legal range 1..15.
- RUN_W, 4, width of the internal run counter; must hold DEBOUNCE.
- EVT_W, 8, width of the rise/fall event counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  eq/lt/gt carry a new verdict this cycle
- eq  input  1  comparator a==b
- lt  input  1  comparator a<b
- gt  input  1  comparator a>b
- clear  input  1  synchronous clear of err and event counters
- above  output  1  debounced level; 1 = input considered above threshold
- rise  output  1  one-cycle pulse on a low-to-high level change
- fall  output  1  one-cycle pulse on a high-to-low level change
- err  output  1  sticky illegal-verdict flag
- rise_count  output  EVT_W  saturating count of rise events
- fall_count  output  EVT_W  saturating count of fall events
- state  output  2  current FSM state, for debug

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=LOW(0), run=0.
  - above=0, rise=0, fall=0, err=0.
  - rise_count=0, fall_count=0.
- Legal sample: in_valid=1 and exactly one of eq/lt/gt is high.
- Illegal sample: in_valid=1 with zero or more than one flag high.
  - err is set at the next edge and stays set until clear or reset.
  - The sample is otherwise ignored: no state, run or counter change.
- in_valid=0: flags are don't-care; all state holds; rise=fall=0.
- States, with encodings: LOW=0, CONF_HI=1, HIGH=2, CONF_LO=3.
- LOW:
  - gt with DEBOUNCE=1 -> HIGH, rise.
  - gt with DEBOUNCE>1 -> CONF_HI, run=1.
  - eq or lt -> stay.
- CONF_HI:
  - gt -> run+1; when run+1==DEBOUNCE -> HIGH, run=0, rise.
  - lt -> LOW, run=0.
  - eq -> hold (run unchanged; this is the hysteresis band).
- HIGH:
  - lt with DEBOUNCE=1 -> LOW, fall.
  - lt with DEBOUNCE>1 -> CONF_LO, run=1.
  - eq or gt -> stay.
- CONF_LO:
  - lt -> run+1; when run+1==DEBOUNCE -> LOW, run=0, fall.
  - gt -> HIGH, run=0.
  - eq -> hold.
- Output mapping: above=1 in HIGH and CONF_LO, 0 in LOW and CONF_HI.
- Latency:
  - The qualifying sample is captured at edge k.
  - above, and rise or fall, change in the cycle following edge k (registered, zero combinational path from inputs).
  - rise/fall are high for exactly one cycle.
- Event counters:
  - rise_count increments with each rise; fall_count with each fall.
  - Both saturate at all-ones; no wrap.
- clear:
  - Zeroes err, rise_count and fall_count at the next edge. It does not affect state, run or above.
  - clear and rise/fall at the same edge: the counter becomes 0 (clear wins), but the pulse is still emitted.
  - clear and an illegal sample at the same edge: err=1 (the new error wins).
- Reset mid-confirmation: rst_n low returns to LOW immediately. A pending run is discarded and no pulse is generated.

Decomposition:
- Package compare_debounce_pkg holds:
  - the state encoding constants LOW, CONF_HI, HIGH, CONF_LO;
  - the DEBOUNCE legal-range bounds.
- Sub-module sat_counter (width-parameterised, inc/clr, saturating) is instantiated twice, for rise_count and fall_count.
- The FSM and run counter stay in the top module.

Test Plan (DEBOUNCE=3, EVT_W=8):
- Reset release, then gt,gt,gt valid on consecutive cycles -> state 0,1,1,2; above=1 and rise=1 one cycle after the third sample; rise_count=1.
- LOW, then gt,eq,eq,gt,gt -> stays CONF_HI through the eq samples; enters HIGH after the 5th sample; exactly one rise.
- HIGH, then lt,lt,gt -> CONF_LO, run=2, then back to HIGH; above stays 1 throughout; no fall.
- in_valid=1 with eq=lt=gt=0, then with lt=gt=1 -> err=1 and state unchanged; clear pulse -> err=0 and counts=0 while above is preserved.
- Drive 300 full rise/fall cycles -> rise_count and fall_count saturate at 255; clear coincident with a rise -> rise_count=0, rise pulse still observed.
- CONF_HI with run=2, assert rst_n=0 asynchronously mid-cycle -> outputs zero immediately; after release, a single gt gives state=1, run=1, no rise.
